// File: rtl/slotmaker_config_table.sv
// Slotmaker config table: 8-entry slot->card-ID table written and read over the config
// interface, plus registered Apple II bus-cycle decode to the owning slot/card.
module slotmaker_config_table #(
    parameter logic [63:0] DEFAULT_CARDS = 64'h0,
    parameter bit          ENABLE_EXPROM = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  cfg_slot,
    input  logic [7:0]  cfg_card_i,
    input  logic        cfg_wr,
    output logic [7:0]  cfg_card_o,
    output logic        cfg_change_o,
    input  logic [15:0] a2_addr,
    input  logic        a2_strobe,
    output logic        sel_valid_o,
    output logic [2:0]  sel_slot_o,
    output logic [7:0]  sel_card_o,
    output logic        devsel_o,
    output logic        iosel_o,
    output logic        iostrobe_o
);

    typedef enum logic [1:0] {
        HIT_NONE,
        HIT_DEVSEL,
        HIT_IOSEL,
        HIT_IOSTROBE
    } hit_kind_e;

    logic [7:0] table_q [8];
    logic       wr_q;
    logic       arm_q;
    logic [2:0] exp_owner_q;
    logic [2:0] exp_owner_d;

    logic [7:0] cfg_card_q;
    logic       cfg_change_q;
    logic       sel_valid_q;
    logic [2:0] sel_slot_q;
    logic [7:0] sel_card_q;
    logic       devsel_q;
    logic       iosel_q;
    logic       iostrobe_q;

    logic       commit;
    logic [7:0] cur_card;
    hit_kind_e  hit_kind;
    logic [2:0] hit_slot;
    logic [7:0] hit_card;
    logic       hit_valid;

    // A write only arms once cfg_wr has been seen low after reset, so a request
    // that straddles reset release is dropped rather than committed late.
    assign commit   = cfg_wr & ~wr_q & arm_q;
    assign cur_card = table_q[cfg_slot];

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        hit_kind    = HIT_NONE;
        hit_slot    = 3'd0;
        exp_owner_d = exp_owner_q;
        if (a2_strobe) begin
            if (a2_addr[15:7] == 9'b1100_0000_1) begin
                hit_kind = HIT_DEVSEL;
                hit_slot = a2_addr[6:4];
            end else if (a2_addr[15:11] == 5'b11000 && a2_addr[10:8] != 3'd0) begin
                hit_kind = HIT_IOSEL;
                hit_slot = a2_addr[10:8];
                if (ENABLE_EXPROM) begin
                    exp_owner_d = a2_addr[10:8];
                end
            end else if (ENABLE_EXPROM && a2_addr[15:11] == 5'b11001) begin
                hit_slot = exp_owner_q;
                if (exp_owner_q != 3'd0) begin
                    hit_kind = HIT_IOSTROBE;
                end
                // $CFFF still reports the old owner, then releases the window.
                if (a2_addr[10:0] == 11'h7FF) begin
                    exp_owner_d = 3'd0;
                end
            end
        end
    end

    assign hit_card  = table_q[hit_slot];
    assign hit_valid = (hit_kind != HIT_NONE) && (hit_card != 8'h00);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the table is a small flop array, so it can and must be reset to DEFAULT_CARDS.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int n = 0; n < 8; n++) begin
                table_q[n] <= DEFAULT_CARDS[8*n +: 8];
            end
            wr_q         <= 1'b0;
            arm_q        <= 1'b0;
            exp_owner_q  <= 3'd0;
            cfg_card_q   <= 8'h00;
            cfg_change_q <= 1'b0;
            sel_valid_q  <= 1'b0;
            sel_slot_q   <= 3'd0;
            sel_card_q   <= 8'h00;
            devsel_q     <= 1'b0;
            iosel_q      <= 1'b0;
            iostrobe_q   <= 1'b0;
        end else begin
            wr_q        <= cfg_wr;
            arm_q       <= arm_q | ~cfg_wr;
            exp_owner_q <= exp_owner_d;

            if (commit) begin
                table_q[cfg_slot] <= cfg_card_i;
            end
            cfg_card_q   <= commit ? cfg_card_i : cur_card;
            cfg_change_q <= commit && (cfg_card_i != cur_card);

            sel_valid_q <= hit_valid;
            devsel_q    <= hit_valid && (hit_kind == HIT_DEVSEL);
            iosel_q     <= hit_valid && (hit_kind == HIT_IOSEL);
            iostrobe_q  <= hit_valid && (hit_kind == HIT_IOSTROBE);
            if (hit_valid) begin
                sel_slot_q <= hit_slot;
                sel_card_q <= hit_card;
            end
        end
    end

    assign cfg_card_o   = cfg_card_q;
    assign cfg_change_o = cfg_change_q;
    assign sel_valid_o  = sel_valid_q;
    assign sel_slot_o   = sel_slot_q;
    assign sel_card_o   = sel_card_q;
    assign devsel_o     = devsel_q;
    assign iosel_o      = iosel_q;
    assign iostrobe_o   = iostrobe_q;

endmodule

// File: tb/tb_slotmaker_config_table.sv
// Directed bench for slotmaker_config_table: config writes/reads, bus decode and
// reset recovery, each compared against hand-computed values.
module tb_slotmaker_config_table;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  cfg_slot;
    logic [7:0]  cfg_card_i;
    logic        cfg_wr;
    logic [7:0]  cfg_card_o;
    logic        cfg_change_o;
    logic [15:0] a2_addr;
    logic        a2_strobe;
    logic        sel_valid_o;
    logic [2:0]  sel_slot_o;
    logic [7:0]  sel_card_o;
    logic        devsel_o;
    logic        iosel_o;
    logic        iostrobe_o;

    int checks = 0;
    int errors = 0;

    slotmaker_config_table #(
        .DEFAULT_CARDS(64'h0000_0000_0003_0000),
        .ENABLE_EXPROM(1'b1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cfg_slot     (cfg_slot),
        .cfg_card_i   (cfg_card_i),
        .cfg_wr       (cfg_wr),
        .cfg_card_o   (cfg_card_o),
        .cfg_change_o (cfg_change_o),
        .a2_addr      (a2_addr),
        .a2_strobe    (a2_strobe),
        .sel_valid_o  (sel_valid_o),
        .sel_slot_o   (sel_slot_o),
        .sel_card_o   (sel_card_o),
        .devsel_o     (devsel_o),
        .iosel_o      (iosel_o),
        .iostrobe_o   (iostrobe_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bus cycle, clock it, and leave the strobe low again.
    task automatic bus(input logic [15:0] addr);
        a2_addr   = addr;
        a2_strobe = 1'b1;
        tick();
        a2_strobe = 1'b0;
    endtask

    task automatic check_sel(input string tag, input logic v, input logic [2:0] s,
                             input logic [7:0] c, input logic d, input logic i, input logic x);
        check({tag, ".valid"},    sel_valid_o, v);
        check({tag, ".slot"},     sel_slot_o,  s);
        check({tag, ".card"},     sel_card_o,  c);
        check({tag, ".devsel"},   devsel_o,    d);
        check({tag, ".iosel"},    iosel_o,     i);
        check({tag, ".iostrobe"}, iostrobe_o,  x);
    endtask

    initial begin
        int pulses;
        resetn     = 1'b0;
        cfg_slot   = 3'd0;
        cfg_card_i = 8'h00;
        cfg_wr     = 1'b0;
        a2_addr    = 16'h0000;
        a2_strobe  = 1'b0;

        // 1. Reset state and default readback.
        tick();
        tick();
        check("rst.card_o", cfg_card_o, 8'h00);
        check("rst.change", cfg_change_o, 1'b0);
        check_sel("rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        resetn   = 1'b1;
        cfg_slot = 3'd2;
        tick();
        check("dflt.slot2", cfg_card_o, 8'h03);
        cfg_slot = 3'd4;
        tick();
        check("dflt.slot4", cfg_card_o, 8'h00);

        // 2. Held write commits once; repeat write of same value reports no change.
        cfg_card_i = 8'h21;
        cfg_wr     = 1'b1;
        tick();
        check("wr.change", cfg_change_o, 1'b1);
        check("wr.bypass", cfg_card_o, 8'h21);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (cfg_change_o) pulses++;
        end
        check("wr.hold_pulses", pulses, 0);
        check("wr.hold_card", cfg_card_o, 8'h21);
        cfg_wr = 1'b0;
        tick();
        cfg_wr = 1'b1;
        tick();
        check("wr.same.change", cfg_change_o, 1'b0);
        check("wr.same.card", cfg_card_o, 8'h21);
        cfg_wr = 1'b0;
        tick();

        // 3. Device-select decode.
        bus(16'hC0C3);
        check_sel("dev.s4", 1'b1, 3'd4, 8'h21, 1'b1, 1'b0, 1'b0);
        tick();
        check("dev.idle.valid", sel_valid_o, 1'b0);
        check("dev.idle.devsel", devsel_o, 1'b0);
        bus(16'hC0D3);
        check_sel("dev.s5empty", 1'b0, 3'd4, 8'h21, 1'b0, 1'b0, 1'b0);
        bus(16'hC080);
        check("dev.s0empty.valid", sel_valid_o, 1'b0);
        bus(16'hC07F);
        check("dev.c07f.valid", sel_valid_o, 1'b0);
        bus(16'hC0A5);
        check_sel("dev.s2", 1'b1, 3'd2, 8'h03, 1'b1, 1'b0, 1'b0);

        // 4. I/O select, expansion-ROM ownership and its $CFFF release.
        bus(16'hC400);
        check_sel("io.s4", 1'b1, 3'd4, 8'h21, 1'b0, 1'b1, 1'b0);
        bus(16'hC9AB);
        check_sel("exp.s4", 1'b1, 3'd4, 8'h21, 1'b0, 1'b0, 1'b1);
        bus(16'hCFFF);
        check_sel("exp.cfff", 1'b1, 3'd4, 8'h21, 1'b0, 1'b0, 1'b1);
        bus(16'hC9AB);
        check("exp.released.valid", sel_valid_o, 1'b0);
        check("exp.released.iostrobe", iostrobe_o, 1'b0);
        // Empty slot still claims the window, so slot 4 no longer owns it.
        bus(16'hC400);
        bus(16'hC100);
        check("io.s1empty.valid", sel_valid_o, 1'b0);
        bus(16'hC800);
        check("exp.s1empty.valid", sel_valid_o, 1'b0);
        bus(16'hD000);
        check("other.valid", sel_valid_o, 1'b0);

        // 5. Commit and strobe in the same cycle: decode sees the old entry.
        cfg_slot   = 3'd4;
        cfg_card_i = 8'h00;
        cfg_wr     = 1'b1;
        bus(16'hC0C0);
        check_sel("race.hit", 1'b1, 3'd4, 8'h21, 1'b1, 1'b0, 1'b0);
        check("race.change", cfg_change_o, 1'b1);
        check("race.card_o", cfg_card_o, 8'h00);
        cfg_wr = 1'b0;
        bus(16'hC0C0);
        check("race.after.valid", sel_valid_o, 1'b0);

        // 6. Reset in the middle of a write while slot 4 owns the window.
        cfg_card_i = 8'h21;
        cfg_wr     = 1'b1;
        tick();
        cfg_wr = 1'b0;
        bus(16'hC400);
        check("pre.io.s4", iosel_o, 1'b1);
        cfg_slot   = 3'd3;
        cfg_card_i = 8'h55;
        cfg_wr     = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("arst.valid", sel_valid_o, 1'b0);
        check("arst.iosel", iosel_o, 1'b0);
        check("arst.card_o", cfg_card_o, 8'h00);
        tick();
        resetn = 1'b1;
        tick();
        check("post.s3.card", cfg_card_o, 8'h00);
        check("post.s3.change", cfg_change_o, 1'b0);
        cfg_slot = 3'd4;
        tick();
        check("post.s4.card", cfg_card_o, 8'h00);
        cfg_slot = 3'd2;
        tick();
        check("post.s2.card", cfg_card_o, 8'h03);
        bus(16'hC9AB);
        check("post.exp.valid", sel_valid_o, 1'b0);
        cfg_slot = 3'd3;
        cfg_wr   = 1'b0;
        tick();
        check("post.nocommit", cfg_card_o, 8'h00);
        cfg_wr = 1'b1;
        tick();
        check("post.commit.change", cfg_change_o, 1'b1);
        check("post.commit.card", cfg_card_o, 8'h55);
        cfg_wr = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
